// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default frame format and parity helper.
// The receiver uses the same defaults so both ends agree on the frame format.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 16;
   localparam int DEFAULT_DATA_BITS    = 8;
   localparam int DEFAULT_PARITY_EN    = 0;
   localparam int DEFAULT_PARITY_ODD   = 0;
   localparam int DEFAULT_STOP_BITS    = 1;
   localparam int MAX_DATA_BITS        = 9;

   // XOR of the low nbits of data, inverted for odd parity.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input int nbits,
                                        input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < nbits) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic bit_end
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: valid/ready byte intake, start/data/parity/stop serialisation.
// All outputs are registered from next-state values so the line changes right after the edge.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEFAULT_DATA_BITS,
   parameter int PARITY_EN    = DEFAULT_PARITY_EN,
   parameter int PARITY_ODD   = DEFAULT_PARITY_ODD,
   parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_serial,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   tx_state_t            state, state_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic [IDX_W-1:0]     bit_idx, bit_idx_next;
   logic                 parity, parity_next;
   logic                 line_next;
   logic                 done_next;
   logic                 handshake;
   logic                 bit_end;

   assign handshake = tx_valid && tx_ready;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clr    (handshake),
      .bit_end(bit_end)
   );

   always_comb begin
      state_next   = state;
      shift_next   = shift;
      bit_idx_next = bit_idx;
      parity_next  = parity;
      done_next    = 1'b0;
      case (state)
         IDLE: begin
            if (handshake) begin
               state_next   = START;
               shift_next   = tx_data;
               bit_idx_next = '0;
               parity_next  = calc_parity(MAX_DATA_BITS'(tx_data), DATA_BITS, (PARITY_ODD != 0));
            end
         end
         START: begin
            if (bit_end) state_next = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_next = shift >> 1;
               if (bit_idx == LAST_DATA) begin
                  bit_idx_next = '0;
                  state_next   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_next = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (bit_idx == LAST_STOP) begin
                  bit_idx_next = '0;
                  state_next   = IDLE;
                  done_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Line value is decoded from the upcoming state so it is valid from the edge onward.
      line_next = 1'b1;
      case (state_next)
         START:   line_next = 1'b0;
         DATA:    line_next = shift_next[0];
         PARITY:  line_next = parity_next;
         default: line_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shift     <= '0;
         bit_idx   <= '0;
         parity    <= 1'b0;
         tx_serial <= 1'b1;
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_next;
         shift     <= shift_next;
         bit_idx   <= bit_idx_next;
         parity    <= parity_next;
         tx_serial <= line_next;
         tx_ready  <= (state_next == IDLE);
         tx_busy   <= (state_next != IDLE);
         tx_done   <= done_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: 8N1, 8E1 and 8O1 instances at 4 clocks per bit, line decoded by a scoreboard monitor.
module tb_uart_tx_engine;

   localparam int CPB = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] d [3];
   logic       v [3];
   logic       serial [3];
   logic       ready [3];
   logic       busy [3];
   logic       done [3];

   int   errors = 0;
   int   checks = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   done_cnt [3];

   always #5 clk = ~clk;

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .reset(reset), .tx_data(d[0]), .tx_valid(v[0]),
      .tx_ready(ready[0]), .tx_serial(serial[0]), .tx_busy(busy[0]), .tx_done(done[0]));

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .reset(reset), .tx_data(d[1]), .tx_valid(v[1]),
      .tx_ready(ready[1]), .tx_serial(serial[1]), .tx_busy(busy[1]), .tx_done(done[1]));

   uart_tx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .reset(reset), .tx_data(d[2]), .tx_valid(v[2]),
      .tx_ready(ready[2]), .tx_serial(serial[2]), .tx_busy(busy[2]), .tx_done(done[2]));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end
   endtask

   task automatic send(input int k, input logic [7:0] data, input logic par, input logic gap, input bit keep);
      exp_t e;
      int   n;
      e.data = data;
      e.par  = par;
      e.gap  = gap;
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
      @(negedge clk);
      v[k] = 1'b1;
      d[k] = data;
      n = 0;
      while (ready[k] !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL handshake_dut%0d: ready never rose within %0d cycles, required 1", k, n);
      end
      @(posedge clk);
      #1;
      if (!keep) v[k] = 1'b0;
   endtask

   // Monitor: decodes each frame from the line cycle by cycle against the queued expectation.
   bit          in_frame [3];
   int          cyc [3];
   int          idle [3];
   int          total [3];
   logic [10:0] line [3];
   bit          bad [3];
   int          bad_at [3];
   logic        bad_got [3];
   logic        bad_req [3];

   initial begin
      exp_t e;
      int   sz;
      for (int k = 0; k < 3; k++) begin
         in_frame[k] = 0; cyc[k] = 0; idle[k] = 1000; total[k] = 0;
         line[k] = '1; bad[k] = 0; bad_at[k] = -1; bad_got[k] = 1'b0; bad_req[k] = 1'b0;
         done_cnt[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!reset) begin
               in_frame[k] = 0;
               idle[k] = 1000;
            end else begin
               if (done[k] === 1'b1) done_cnt[k]++;
               if (in_frame[k] && cyc[k] == total[k]) begin
                  checks++;
                  if (bad[k] || done[k] !== 1'b1 || serial[k] !== 1'b1 || ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
                     errors++;
                     $display("FAIL frame_dut%0d: cycle %0d line=%b required %b; at end serial=%b ready=%b busy=%b done=%b required 1 1 0 1",
                              k, bad_at[k], bad_got[k], bad_req[k], serial[k], ready[k], busy[k], done[k]);
                  end
                  in_frame[k] = 0;
                  idle[k] = 0;
               end else if (!in_frame[k]) begin
                  if (done[k] === 1'b1) begin
                     checks++;
                     errors++;
                     $display("FAIL stray_done_dut%0d: done=1 outside frame end, required 0", k);
                  end
                  if (serial[k] === 1'b0) begin
                     case (k)
                        0:       sz = q0.size();
                        1:       sz = q1.size();
                        default: sz = q2.size();
                     endcase
                     if (sz == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame_dut%0d: start bit seen, queue size %0d required >0", k, sz);
                        e = '0;
                     end else begin
                        case (k)
                           0:       e = q0.pop_front();
                           1:       e = q1.pop_front();
                           default: e = q2.pop_front();
                        endcase
                     end
                     if (e.gap) begin
                        checks++;
                        if (idle[k] != 0) begin
                           errors++;
                           $display("FAIL gap_dut%0d: %0d idle cycles after done cycle, required 0", k, idle[k]);
                        end
                     end
                     line[k] = '1;
                     line[k][0] = 1'b0;
                     for (int i = 0; i < 8; i++) line[k][i+1] = e.data[i];
                     if (k > 0) line[k][9] = e.par;
                     total[k] = ((k == 0) ? 10 : 11) * CPB;
                     cyc[k] = 0;
                     bad[k] = 0;
                     bad_at[k] = -1;
                     in_frame[k] = 1;
                  end else begin
                     idle[k]++;
                  end
               end
               if (in_frame[k] && cyc[k] < total[k]) begin
                  if (!bad[k] && (serial[k] !== line[k][cyc[k]/CPB] || busy[k] !== 1'b1 ||
                                  ready[k] !== 1'b0 || done[k] !== 1'b0)) begin
                     bad[k] = 1;
                     bad_at[k] = cyc[k];
                     bad_got[k] = serial[k];
                     bad_req[k] = line[k][cyc[k]/CPB];
                  end
                  cyc[k]++;
               end
            end
         end
      end
   end

   initial begin
      bit ok [3];
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0;
         d[k] = 8'h00;
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset_outputs_dut%0d", k), {28'd0, serial[k], ready[k], busy[k], done[k]}, 32'hC);
      reset = 1'b1;

      for (int k = 0; k < 3; k++) ok[k] = 1;
      repeat (100) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            if (serial[k] !== 1'b1 || ready[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) ok[k] = 0;
      end
      for (int k = 0; k < 3; k++) chk($sformatf("idle_100_dut%0d", k), {31'd0, ok[k]}, 32'd1);

      // Basic 8N1 frame.
      send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (50) @(negedge clk);

      // Parity frames: A5 even->0, A5 odd->1, 07 even->1.
      send(1, 8'hA5, 1'b0, 1'b0, 1'b0);
      send(2, 8'hA5, 1'b1, 1'b0, 1'b0);
      send(1, 8'h07, 1'b1, 1'b0, 1'b0);
      repeat (60) @(negedge clk);

      // Back-to-back with valid held high.
      send(0, 8'h55, 1'b0, 1'b0, 1'b1);
      send(0, 8'h0F, 1'b0, 1'b1, 1'b0);
      repeat (50) @(negedge clk);

      // Inputs wiggled mid-frame must not disturb the byte in flight.
      send(0, 8'h96, 1'b0, 1'b0, 1'b0);
      ok[0] = 1;
      repeat (20) begin
         @(negedge clk);
         v[0] = 1'($urandom_range(0, 1));
         d[0] = 8'($urandom);
         if (ready[0] !== 1'b0) ok[0] = 0;
      end
      v[0] = 1'b0;
      chk("ready_low_mid_frame", {31'd0, ok[0]}, 32'd1);
      repeat (50) @(negedge clk);

      // Reset during data bit 3 (a zero bit of A5), then a clean 3C frame.
      send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (17) @(posedge clk);
      #2;
      chk("data_bit3_low", {31'd0, serial[0]}, 32'd0);
      reset = 1'b0;
      #1;
      chk("abort_line_high", {31'd0, serial[0]}, 32'd1);
      chk("abort_busy_low", {31'd0, busy[0]}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
      repeat (60) @(negedge clk);

      chk("queue_empty_dut0", q0.size(), 32'd0);
      chk("queue_empty_dut1", q1.size(), 32'd0);
      chk("queue_empty_dut2", q2.size(), 32'd0);
      chk("done_count_dut0", done_cnt[0], 32'd5);
      chk("done_count_dut1", done_cnt[1], 32'd2);
      chk("done_count_dut2", done_cnt[2], 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      checks++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
